// File: rtl/mul_iter.sv
// Iterative multiply / multiply-accumulate unit (MUL, MLA, UMULL, UMLAL, SMULL, SMLAL).
// Start/Busy/Done handshake; BITS_PER_CYCLE multiplier bits are retired per RUN cycle.
module mul_iter #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [2:0]         MulOp,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   AccLo,
  input  logic [WIDTH-1:0]   AccHi,
  input  logic               CIn,
  input  logic               VIn,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   ResultLo,
  output logic [WIDTH-1:0]   ResultHi,
  output logic [3:0]         Flags
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int MW = WIDTH + BITS_PER_CYCLE;
  localparam int NM = 1 << BITS_PER_CYCLE;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [PW-1:0]             prod_q, prod_d;
  logic [PW-1:0]             acc_q, acc_d;
  logic [MW-1:0]             mult_q [NM];
  logic [MW-1:0]             mult_d [NM];
  logic                      long_q, long_d;
  logic                      neg_q, neg_d;
  logic                      c_q, c_d;
  logic                      v_q, v_d;
  logic [WIDTH-1:0]          lo_q, lo_d;
  logic [WIDTH-1:0]          hi_q, hi_d;
  logic [3:0]                flags_q, flags_d;

  logic                      launch;
  logic                      is_signed;
  logic [WIDTH-1:0]          a_mag;
  logic [WIDTH-1:0]          b_mag;
  logic [BITS_PER_CYCLE-1:0] digit;
  logic [MW-1:0]             step_sum;
  logic [PW-1:0]             fixed;
  logic [PW-1:0]             total;

  assign launch    = Start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign is_signed = MulOp[2] & MulOp[1];
  assign a_mag     = (is_signed && A[WIDTH-1]) ? -A : A;
  assign b_mag     = (is_signed && B[WIDTH-1]) ? -B : B;

  // Multiplier lives in the low half of the product register and is shifted
  // out LSB-first while the partial sum grows into the high half.
  assign digit     = prod_q[BITS_PER_CYCLE-1:0];
  assign step_sum  = MW'(prod_q[PW-1:WIDTH]) + mult_q[digit];

  assign fixed     = neg_q ? -prod_q : prod_q;
  assign total     = fixed + acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      long_q  <= 1'b0;
      neg_q   <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      for (int unsigned k = 0; k < NM; k++) begin
        mult_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      long_q  <= long_d;
      neg_q   <= neg_d;
      c_q     <= c_d;
      v_q     <= v_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
      mult_q  <= mult_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_RUN;
          cnt_d   = CW'(N - 1);
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (Start) begin
          state_d = S_RUN;
          cnt_d   = CW'(N - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    prod_d  = prod_q;
    acc_d   = acc_q;
    mult_d  = mult_q;
    long_d  = long_q;
    neg_d   = neg_q;
    c_d     = c_q;
    v_d     = v_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    flags_d = flags_q;

    if (launch) begin
      prod_d = {{WIDTH{1'b0}}, b_mag};
      long_d = MulOp[2];
      neg_d  = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
      c_d    = CIn;
      v_d    = VIn;
      // Accumulator is resolved at launch so FIX adds it unconditionally.
      if (MulOp[2]) begin
        acc_d = MulOp[0] ? {AccHi, AccLo} : '0;
      end else begin
        acc_d = (MulOp == 3'b001) ? {{WIDTH{1'b0}}, AccLo} : '0;
      end
      for (int unsigned k = 0; k < NM; k++) begin
        mult_d[k] = MW'(a_mag) * MW'(k);
      end
    end else if (state_q == S_RUN) begin
      prod_d = {step_sum, prod_q[WIDTH-1:BITS_PER_CYCLE]};
    end

    if (state_q == S_FIX) begin
      lo_d = total[WIDTH-1:0];
      hi_d = long_q ? total[PW-1:WIDTH] : '0;
      flags_d[3] = long_q ? total[PW-1] : total[WIDTH-1];
      flags_d[2] = long_q ? (total == '0) : (total[WIDTH-1:0] == '0);
      flags_d[1] = c_q;
      flags_d[0] = v_q;
    end
  end

  assign Busy     = (state_q == S_RUN) || (state_q == S_FIX);
  assign Done     = (state_q == S_DONE);
  assign ResultLo = lo_q;
  assign ResultHi = hi_q;
  assign Flags    = flags_q;

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter: 32/1, 32/4 and 8/2 instances, directed vectors,
// handshake corner cases and an 8-bit random sweep against a behavioural model.
module tb_mul_iter;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [3:0]  fl;
    int          due;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alo;
    logic [31:0] ahi;
    logic        c;
    logic        v;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [3:0]  fl;
  } vec_t;

  localparam int N1 = 32;
  localparam int N4 = 8;
  localparam int N8 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk  = 0;
  int nfail = 0;
  bit go    = 1'b0;

  logic        rst1, rst4, rst8, st1, st4, st8;
  logic [2:0]  op, op8;
  logic [31:0] a, b, alo, ahi;
  logic [7:0]  a8, b8, alo8, ahi8;
  logic        cin, vin, cin8, vin8;

  logic        busy1, done1, busy4, done4, busy8, done8;
  logic [31:0] lo1, hi1, lo4, hi4;
  logic [7:0]  lo8, hi8;
  logic [3:0]  fl1, fl4, fl8;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q8[$];
  exp_t e1, e4, e8;
  vec_t vecs[12];

  mul_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_d1 (
    .clk(clk), .reset(rst1), .Start(st1), .MulOp(op), .A(a), .B(b),
    .AccLo(alo), .AccHi(ahi), .CIn(cin), .VIn(vin), .Busy(busy1), .Done(done1),
    .ResultLo(lo1), .ResultHi(hi1), .Flags(fl1));

  mul_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_d4 (
    .clk(clk), .reset(rst4), .Start(st4), .MulOp(op), .A(a), .B(b),
    .AccLo(alo), .AccHi(ahi), .CIn(cin), .VIn(vin), .Busy(busy4), .Done(done4),
    .ResultLo(lo4), .ResultHi(hi4), .Flags(fl4));

  mul_iter #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_d8 (
    .clk(clk), .reset(rst8), .Start(st8), .MulOp(op8), .A(a8), .B(b8),
    .AccLo(alo8), .AccHi(ahi8), .CIn(cin8), .VIn(vin8), .Busy(busy8), .Done(done8),
    .ResultLo(lo8), .ResultHi(hi8), .Flags(fl8));

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic exp_t model8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                  input logic [7:0] al, input logic [7:0] ah,
                                  input logic c, input logic v);
    logic signed [15:0] sx, sy;
    logic [15:0] p, r;
    exp_t e;
    sx = {{8{x[7]}}, x};
    sy = {{8{y[7]}}, y};
    if (o[2:1] == 2'b11) p = sx * sy;
    else p = {8'd0, x} * {8'd0, y};
    if (o[2]) begin
      r    = p + (o[0] ? {ah, al} : 16'd0);
      e.lo = {24'd0, r[7:0]};
      e.hi = {24'd0, r[15:8]};
      e.fl = {r[15], r == 16'd0, c, v};
    end else begin
      r    = p + ((o == 3'b001) ? {8'd0, al} : 16'd0);
      e.lo = {24'd0, r[7:0]};
      e.hi = 32'd0;
      e.fl = {r[7], r[7:0] == 8'd0, c, v};
    end
    e.due = 0;
    return e;
  endfunction

  task automatic launch32(input int which, input vec_t v, input bit push);
    exp_t e;
    op = v.op; a = v.a; b = v.b; alo = v.alo; ahi = v.ahi; cin = v.c; vin = v.v;
    e.lo = v.lo; e.hi = v.hi; e.fl = v.fl;
    e.due = cyc + ((which == 1) ? N1 : N4) + 2;
    if (push) begin
      if (which == 1) q1.push_back(e);
      else q4.push_back(e);
    end
    if (which == 1) st1 = 1'b1;
    else st4 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0;
    st4 = 1'b0;
  endtask

  task automatic launch8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] al, input logic [7:0] ah, input logic c, input logic v);
    exp_t e;
    op8 = o; a8 = x; b8 = y; alo8 = al; ahi8 = ah; cin8 = c; vin8 = v;
    e = model8(o, x, y, al, ah, c, v);
    e.due = cyc + N8 + 2;
    q8.push_back(e);
    st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (go) begin
      check("d1_busy_done_excl", busy1 & done1, 0);
      check("d1_no_stray_done", done1 && (q1.size() == 0), 0);
      if (done1 && q1.size() != 0) begin
        e1 = q1.pop_front();
        check("d1_lo", lo1, e1.lo);
        check("d1_hi", hi1, e1.hi);
        check("d1_flags", fl1, e1.fl);
        check("d1_latency", cyc, e1.due);
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      check("d4_busy_done_excl", busy4 & done4, 0);
      check("d4_no_stray_done", done4 && (q4.size() == 0), 0);
      if (done4 && q4.size() != 0) begin
        e4 = q4.pop_front();
        check("d4_lo", lo4, e4.lo);
        check("d4_hi", hi4, e4.hi);
        check("d4_flags", fl4, e4.fl);
        check("d4_latency", cyc, e4.due);
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      check("d8_busy_done_excl", busy8 & done8, 0);
      check("d8_no_stray_done", done8 && (q8.size() == 0), 0);
      if (done8 && q8.size() != 0) begin
        e8 = q8.pop_front();
        check("d8_lo", {24'd0, lo8}, e8.lo);
        check("d8_hi", {24'd0, hi8}, e8.hi);
        check("d8_flags", fl8, e8.fl);
        check("d8_latency", cyc, e8.due);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    vec_t hv;
    int   t;

    vecs[0]  = '{3'b000, 32'd7, 32'd6, 32'd0, 32'd0, 1'b1, 1'b0, 32'd42, 32'd0, 4'b0010};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'd2, 32'd2, 32'hDEADBEEF, 1'b0, 1'b1, 32'd0, 32'd0, 4'b0101};
    vecs[2]  = '{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFE, 4'b1000};
    vecs[3]  = '{3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, 1'b1, 32'h00000001, 32'h00000000, 4'b0011};
    vecs[4]  = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 4'b1000};
    vecs[5]  = '{3'b101, 32'h00010000, 32'h00010000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000002, 4'b0000};
    vecs[6]  = '{3'b110, 32'd0, 32'd5, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0100};
    vecs[7]  = '{3'b011, 32'd3, 32'd5, 32'd100, 32'd0, 1'b0, 1'b0, 32'd15, 32'd0, 4'b0000};
    vecs[8]  = '{3'b110, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFFFFF1, 32'hFFFFFFFF, 4'b1000};
    vecs[9]  = '{3'b000, 32'h00010000, 32'h00010000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0100};
    vecs[10] = '{3'b111, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 1'b0, 1'b0, 32'h00000000, 32'h40000000, 4'b0000};
    vecs[11] = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000, 32'hFFFFFFFE, 4'b1010};

    rst1 = 1'b1; rst4 = 1'b1; rst8 = 1'b1;
    st1 = 1'b0; st4 = 1'b0; st8 = 1'b0;
    op = '0; a = '0; b = '0; alo = '0; ahi = '0; cin = 1'b0; vin = 1'b0;
    op8 = '0; a8 = '0; b8 = '0; alo8 = '0; ahi8 = '0; cin8 = 1'b0; vin8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst1 = 1'b0; rst4 = 1'b0; rst8 = 1'b0;
    go = 1'b1;
    @(negedge clk);
    check("d1_reset_state", {busy1, done1, fl1, hi1, lo1}, 0);
    check("d4_reset_state", {busy4, done4, fl4, hi4, lo4}, 0);
    check("d8_reset_state", {busy8, done8, fl8, hi8, lo8}, 0);
    @(posedge clk); #1;

    // Directed vectors; odd entries relaunch during the Done cycle.
    for (int i = 0; i < 12; i++) begin
      launch32(1, vecs[i], 1'b1);
      repeat (N1 + 1 + (i % 2)) @(posedge clk);
      #1;
    end
    for (int i = 0; i < 12; i++) begin
      launch32(4, vecs[i], 1'b1);
      repeat (N4 + 1 + (i % 2)) @(posedge clk);
      #1;
    end
    repeat (N1 + 4) @(posedge clk);
    #1;

    // Start held high while Busy: one completion, first operands only.
    hv = '{3'b000, 32'h12345678, 32'h10, 32'd0, 32'd0, 1'b0, 1'b0, 32'h23456780, 32'd0, 4'b0000};
    launch32(1, hv, 1'b1);
    st1 = 1'b1;
    for (int j = 0; j <= N1; j++) begin
      a = 32'(j + 1);
      b = 32'd3;
      op = 3'b100;
      @(posedge clk); #1;
    end
    st1 = 1'b0;
    repeat (N1 + 4) @(posedge clk);
    #1;

    // Start during Done launches back-to-back.
    hv = '{3'b000, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 32'd12, 32'd0, 4'b0000};
    launch32(1, hv, 1'b1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done1 && t < 100);
    check("d1_b2b_first_done_seen", done1, 1);
    hv = '{3'b000, 32'd5, 32'd5, 32'd0, 32'd0, 1'b1, 1'b1, 32'd25, 32'd0, 4'b0011};
    launch32(1, hv, 1'b1);
    check("d1_b2b_busy_next", busy1, 1);
    repeat (N1 + 4) @(posedge clk);
    #1;

    // Reset mid-RUN, with Start on the same edge: the op is discarded.
    launch32(1, vecs[2], 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst1 = 1'b1;
    st1  = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    st1  = 1'b0;
    @(negedge clk);
    check("d1_midrun_reset", {busy1, done1, fl1, hi1, lo1}, 0);
    repeat (N1 + 6) @(posedge clk);
    #1;
    launch32(1, vecs[4], 1'b1);
    repeat (N1 + 3) @(posedge clk);
    #1;

    // 8-bit instance: corner cases then random sweep.
    launch8(3'b110, 8'h80, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1);
    repeat (N8 + 2) @(posedge clk); #1;
    launch8(3'b111, 8'h80, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
    repeat (N8 + 2) @(posedge clk); #1;
    launch8(3'b101, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    repeat (N8 + 1) @(posedge clk); #1;
    launch8(3'b001, 8'hFF, 8'h02, 8'h02, 8'h55, 1'b1, 1'b1);
    repeat (N8 + 2) @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      launch8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 1'($urandom), 1'($urandom));
      repeat (N8 + 1 + $urandom_range(0, 1)) @(posedge clk);
      #1;
    end

    repeat (N1 + 10) @(posedge clk);
    @(negedge clk);
    check("d1_all_done", q1.size(), 0);
    check("d4_all_done", q4.size(), 0);
    check("d8_all_done", q8.size(), 0);
    go = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
